// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-index width, hazard FSM state
// encoding and the control-word shapes the hazard unit drives.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // A pipeline register cleared to NOP is driven with a 1 on its flush line.
    localparam logic CLEAR_TO_NOP = 1'b1;

    // Bundled enables/clears, MSB first in port order.
    typedef struct packed {
        logic pc_write_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic id_ex_bubble;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN      = ctrl_t'(9'b11111_0_000);
    localparam ctrl_t CTRL_FREEZE   = ctrl_t'(9'b00000_0_000);
    localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(9'b00111_1_000);

    // Taken branch: every stage advances so the PC loads the target, while
    // the three younger stages are cleared to NOP.
    function automatic ctrl_t flush_ctrl();
        ctrl_t c;
        c              = CTRL_RUN;
        c.flush_if_id  = CLEAR_TO_NOP;
        c.flush_id_ex  = CLEAR_TO_NOP;
        c.flush_ex_mem = CLEAR_TO_NOP;
        return c;
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Free-running performance counter: increments on inc, wraps silently at
// all-ones, synchronous clear, asynchronous reset.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count register; the adder simply rolls over, no saturation.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard stall/flush unit: load-use stall, data-memory freeze, taken-branch
// flush (deferred while frozen), plus stall and flush counters.
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [REG_ADDR_W-1:0] Rs1_IF_ID,
    input  logic [REG_ADDR_W-1:0] Rs2_IF_ID,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    input  logic [REG_ADDR_W-1:0] Rd_ID_EX,
    input  logic                  MemRead_ID_EX,
    input  logic                  mem_access_EX_MEM,
    input  logic                  dmem_ready,
    input  logic                  branch_taken_EX_MEM,
    output logic                  pc_write_en,
    output logic                  IF_ID_en,
    output logic                  ID_EX_en,
    output logic                  EX_MEM_en,
    output logic                  MEM_WB_en,
    output logic                  ID_EX_bubble,
    output logic                  flush_IF_ID,
    output logic                  flush_ID_EX,
    output logic                  flush_EX_MEM,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    state_t state_q, state_d;
    logic   pend_q, pend_d;
    logic   load_use, mem_busy, flush_req;
    logic   stall_inc, flush_inc;
    ctrl_t  ctrl;

    // Hazard detection; a load into x0 never stalls.
    assign load_use = MemRead_ID_EX && (Rd_ID_EX != '0) &&
                      ((use_rs1 && (Rs1_IF_ID == Rd_ID_EX)) ||
                       (use_rs2 && (Rs2_IF_ID == Rd_ID_EX)));
    assign mem_busy  = mem_access_EX_MEM && !dmem_ready;
    assign flush_req = branch_taken_EX_MEM || pend_q;

    // State and pending-branch registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Next state and control outputs; priority freeze > flush > load-use.
    always_comb begin
        ctrl      = CTRL_RUN;
        state_d   = state_q;
        pend_d    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        case (state_q)
            RUN:      if (mem_busy)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_busy) state_d = RUN;
            default:  state_d = RUN;
        endcase

        if (mem_busy) begin
            // Hold a branch seen during the freeze until the memory releases.
            ctrl      = CTRL_FREEZE;
            pend_d    = pend_q || branch_taken_EX_MEM;
            stall_inc = 1'b1;
        end else if (flush_req) begin
            // ID instruction is wrong-path here, so any load-use is moot.
            ctrl      = flush_ctrl();
            flush_inc = 1'b1;
        end else if (load_use) begin
            ctrl      = CTRL_LOAD_USE;
            stall_inc = 1'b1;
        end

        // While in reset the pipeline sees plain "run" controls.
        if (arst) begin
            ctrl = CTRL_RUN;
        end
    end

    assign pc_write_en  = ctrl.pc_write_en;
    assign IF_ID_en     = ctrl.if_id_en;
    assign ID_EX_en     = ctrl.id_ex_en;
    assign EX_MEM_en    = ctrl.ex_mem_en;
    assign MEM_WB_en    = ctrl.mem_wb_en;
    assign ID_EX_bubble = ctrl.id_ex_bubble;
    assign flush_IF_ID  = ctrl.flush_if_id;
    assign flush_ID_EX  = ctrl.flush_id_ex;
    assign flush_EX_MEM = ctrl.flush_ex_mem;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .arst  (arst),
        .clear (1'b0),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .arst  (arst),
        .clear (1'b0),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized checks of hazard_stall_unit against a behavioural
// model of the stall/flush rules.
module tb_hazard_stall_unit;

    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic [AW-1:0] rs1, rs2, rd;
    logic          use1, use2, memread, memacc, dready, btaken;
    logic          pc_we, ifid_en, idex_en, exmem_en, memwb_en, bubble;
    logic          f_ifid, f_idex, f_exmem;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit      m_pend;
    bit      m_wait;
    int unsigned m_stall;
    int unsigned m_flush;

    hazard_stall_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk                 (clk),
        .arst                (arst),
        .Rs1_IF_ID           (rs1),
        .Rs2_IF_ID           (rs2),
        .use_rs1             (use1),
        .use_rs2             (use2),
        .Rd_ID_EX            (rd),
        .MemRead_ID_EX       (memread),
        .mem_access_EX_MEM   (memacc),
        .dmem_ready          (dready),
        .branch_taken_EX_MEM (btaken),
        .pc_write_en         (pc_we),
        .IF_ID_en            (ifid_en),
        .ID_EX_en            (idex_en),
        .EX_MEM_en           (exmem_en),
        .MEM_WB_en           (memwb_en),
        .ID_EX_bubble        (bubble),
        .flush_IF_ID         (f_ifid),
        .flush_ID_EX         (f_idex),
        .flush_EX_MEM        (f_exmem),
        .stall_cnt           (stall_cnt),
        .flush_cnt           (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {pc_we, ifid_en, idex_en, exmem_en, memwb_en, bubble, f_ifid, f_idex, f_exmem};
    endfunction

    function automatic bit m_load_use();
        return memread && (rd != 0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    endfunction

    // Expected control word {pc,ifid,idex,exmem,memwb,bubble,fl1,fl2,fl3}.
    function automatic logic [8:0] m_outs();
        bit busy;
        busy = memacc && !dready;
        if (arst)                 return 9'b11111_0_000;
        if (busy)                 return 9'b00000_0_000;
        if (btaken || m_pend)     return 9'b11111_0_111;
        if (m_load_use())         return 9'b00111_1_000;
        return 9'b11111_0_000;
    endfunction

    // Advance the model by one rising edge.
    task automatic m_clock();
        bit busy;
        busy = memacc && !dready;
        if (busy) begin
            m_stall++;
            m_pend = m_pend || btaken;
        end else begin
            if (btaken || m_pend) m_flush++;
            else if (m_load_use()) m_stall++;
            m_pend = 1'b0;
        end
        m_wait = busy;
    endtask

    task automatic m_reset();
        m_pend = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    endtask

    // One transaction: check comb outputs, clock, check registered state.
    task automatic step(input string tag);
        #1;
        chk({tag, ".outs"}, {23'd0, outs()}, {23'd0, m_outs()});
        @(posedge clk);
        m_clock();
        #1;
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
        chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
        chk({tag, ".state"}, {31'd0, dut.state_q}, {31'd0, m_wait});
        $display("step %-12s outs=%09b stall=%0d flush=%0d", tag, outs(), stall_cnt, flush_cnt);
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0; memread = 0;
        memacc = 0; dready = 1; btaken = 0;
    endtask

    initial begin
        idle();
        arst = 1'b1;
        m_reset();
        #1;
        chk("rst.outs", {23'd0, outs()}, {23'd0, 9'b11111_0_000});
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall_cnt", stall_cnt, 0);
        chk("rst.flush_cnt", flush_cnt, 0);
        @(negedge clk);
        arst = 1'b0;

        // Load-use on rs2, then bubble in EX
        memread = 1; rd = 5; rs2 = 5; use2 = 1;
        step("loaduse");
        memread = 0;
        step("after_bub");

        // x0 and unused-source cases
        memread = 1; rd = 0; rs1 = 0; use1 = 1; rs2 = 0; use2 = 1;
        step("rd_x0");
        rd = 7; rs1 = 7; use1 = 0; rs2 = 3; use2 = 1;
        step("unused_rs1");
        rs1 = 7; use1 = 1;
        step("loaduse_rs1");
        idle();

        // Memory wait three cycles then release
        memacc = 1; dready = 0;
        repeat (3) step("memwait");
        dready = 1;
        step("mem_release");
        idle();

        // Branch with simultaneous load-use
        btaken = 1; memread = 1; rd = 9; rs1 = 9; use1 = 1;
        step("branch_lu");
        idle();

        // Branch during freeze, held through release
        memacc = 1; dready = 0; btaken = 1;
        repeat (2) step("br_freeze");
        dready = 1;
        step("br_release");
        btaken = 0; memacc = 0;
        step("br_after");

        // Branch pulse only during the freeze
        memacc = 1; dready = 0; btaken = 1;
        step("br_pulse");
        btaken = 0;
        step("br_hold");
        dready = 1;
        step("br_pend_fire");
        idle();

        // Reset mid-freeze with a pending branch
        memacc = 1; dready = 0; btaken = 1;
        repeat (2) step("pre_rst");
        btaken = 0;
        #2;
        arst = 1'b1;
        m_reset();
        #1;
        chk("rst_mid.outs", {23'd0, outs()}, {23'd0, 9'b11111_0_000});
        chk("rst_mid.stall_cnt", stall_cnt, 0);
        chk("rst_mid.flush_cnt", flush_cnt, 0);
        chk("rst_mid.state", {31'd0, dut.state_q}, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        dready = 1;
        step("post_rst");
        idle();
        step("post_rst_idle");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rs1     = AW'($urandom_range(0, 3));
            rs2     = AW'($urandom_range(0, 3));
            rd      = AW'($urandom_range(0, 3));
            use1    = 1'($urandom);
            use2    = 1'($urandom);
            memread = 1'($urandom);
            memacc  = ($urandom_range(0, 2) == 0);
            dready  = 1'($urandom);
            btaken  = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
